// File: rtl/cla_pkg.sv
// Shared 4-bit carry-lookahead definitions used by the CLA adder/subtractor datapaths.
package cla_pkg;

   localparam int GRP_W = 4;

   // c[i] is the carry out of bit i, each term expanded directly from p/g/cin.
   function automatic logic [GRP_W-1:0] cla4_carry(input logic [GRP_W-1:0] p,
                                                   input logic [GRP_W-1:0] g,
                                                   input logic             cin);
      logic [GRP_W-1:0] c;
      c[0] = g[0] | (p[0] & cin);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit lookahead slice: sum, carry out and group propagate/generate.
module cla4_group
   import cla_pkg::*;
(
   input  logic [GRP_W-1:0] a,
   input  logic [GRP_W-1:0] nb,
   input  logic             cin,
   output logic [GRP_W-1:0] s,
   output logic             cout,
   output logic             grp_p,
   output logic             grp_g
);

   logic [GRP_W-1:0] p;
   logic [GRP_W-1:0] g;
   logic [GRP_W-1:0] c;

   assign p     = a ^ nb;
   assign g     = a & nb;
   assign c     = cla4_carry(p, g, cin);
   assign s     = p ^ {c[GRP_W-2:0], cin};
   assign cout  = c[GRP_W-1];
   assign grp_p = &p;
   assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined a - b - bin (as a + ~b + ~bin), one 4-bit lookahead group per stage, latency WIDTH/4.
// A held output (out_valid & ~out_ready) freezes every stage and drops in_ready in the same cycle.
module cla_sub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 16   // multiple of 4, at least 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / GRP_W;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] nb;
      logic [WIDTH-1:0] sum_lo;
      logic             cy;
   } stage_t;

   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < NG; k++) begin : stg
      stage_t           cur;
      stage_t           nxt;
      logic [GRP_W-1:0] s;
      logic             cout;
      logic             grp_p;
      logic             grp_g;

      if (k == 0) begin : g_src
         assign cur = '{valid: in_valid, a: a, nb: ~b, sum_lo: '0, cy: ~bin};
      end else begin : g_src
         stage_t q;
         // Only the valid bit moves through a bubble, so operand/result fields keep their last values.
         always_ff @(posedge clk) begin
            if (rst) begin
               q <= '0;
            end else if (!stall) begin
               if (stg[k-1].nxt.valid) q <= stg[k-1].nxt;
               else                    q.valid <= 1'b0;
            end
         end
         assign cur = q;
      end

      cla4_group u_grp (
         .a     (cur.a[k*GRP_W +: GRP_W]),
         .nb    (cur.nb[k*GRP_W +: GRP_W]),
         .cin   (cur.cy),
         .s     (s),
         .cout  (cout),
         .grp_p (grp_p),
         .grp_g (grp_g)
      );

      always_comb begin
         nxt                           = cur;
         nxt.sum_lo[k*GRP_W +: GRP_W]  = s;
         nxt.cy                        = cout;
      end

      // The ripple-free carry must agree with the group propagate/generate form.
      always_comb begin
         assert (cout == (grp_g | (grp_p & cur.cy)));
      end
   end

   // Carry into the MSB recovered from its sum bit: s = a ^ nb ^ c_in.
   logic msb_cin;
   logic unused_ops;
   assign msb_cin    = stg[NG-1].nxt.sum_lo[WIDTH-1] ^ stg[NG-1].nxt.a[WIDTH-1]
                     ^ stg[NG-1].nxt.nb[WIDTH-1];
   assign unused_ops = ^{stg[NG-1].nxt.a, stg[NG-1].nxt.nb};

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (!stall) begin
         out_valid <= stg[NG-1].nxt.valid;
         if (stg[NG-1].nxt.valid) begin
            diff <= stg[NG-1].nxt.sum_lo;
            bout <= ~stg[NG-1].nxt.cy;
            ovf  <= msb_cin ^ stg[NG-1].nxt.cy;
            zero <= (stg[NG-1].nxt.sum_lo == '0);
         end
      end
   end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Scoreboarded bench for cla_sub_pipe (WIDTH=16) against an integer-arithmetic reference.
module tb_cla_sub_pipe;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   logic         zero;

   res_t sb[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

   always #5 clk = ~clk;

   cla_sub_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   task automatic check(input bit ok, input string name, input string detail);
      n_chk++;
      if (ok) n_pass++;
      else    $display("FAIL %s: %s", name, detail);
   endtask

   // Reference: plain unsigned and signed integer subtraction.
   function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
      res_t e;
      int   ua;
      int   ub;
      int   r;
      ua     = int'(ta);
      ub     = int'(tb_);
      r      = ua - ub - int'(tbin);
      e.diff = r[W-1:0];
      e.bout = (r < 0);
      r      = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
      e.ovf  = (r > 32767) || (r < -32768);
      e.zero = (e.diff == '0);
      return e;
   endfunction

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                       input res_t exp);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a        = ta;
      b        = tb_;
      bin      = tbin;
      #1;
      while (!in_ready) begin
         n++;
         if (n > 2000) begin
            check(1'b0, "in_ready_timeout", $sformatf("in_ready=%b after %0d cycles, want 1", in_ready, n));
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         #1;
      end
      sb.push_back(exp);
      @(posedge clk);
   endtask

   task automatic rand_op();
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         z;
      x = 16'($urandom());
      y = ($urandom_range(0, 15) == 0) ? x : 16'($urandom());
      z = 1'($urandom_range(0, 1));
      send(x, y, z, model(x, y, z));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end
      check(sb.size() == 0, "drain", $sformatf("%0d results outstanding, want 0", sb.size()));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // out_ready is changed only on falling edges.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = ($urandom_range(0, 9) < 8);
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: a transfer happens at the next rising edge when valid & ready hold now.
   initial begin
      res_t got;
      res_t exp;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            got = {diff, bout, ovf, zero};
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_output", $sformatf("got diff=%h with nothing expected", diff));
            end else begin
               exp = sb.pop_front();
               check(got == exp, "result",
                     $sformatf("got diff=%h bout=%b ovf=%b zero=%b, want diff=%h bout=%b ovf=%b zero=%b",
                               got.diff, got.bout, got.ovf, got.zero,
                               exp.diff, exp.bout, exp.ovf, exp.zero));
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached with %0d results outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin : main
      int c;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      bin      = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check(out_valid == 1'b0, "reset_out_valid", $sformatf("got %b want 0", out_valid));
      check(diff == '0, "reset_diff", $sformatf("got %h want 0000", diff));
      check({bout, ovf, zero} == 3'b000, "reset_flags", $sformatf("got %b want 000", {bout, ovf, zero}));
      check(in_ready == 1'b1, "reset_in_ready", $sformatf("got %b want 1", in_ready));

      // First op into an empty pipe: result visible 4 cycles after acceptance.
      send(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0, 1'b0});
      c = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         c++;
      end while (!out_valid && c < 20);
      check(c == 4, "latency", $sformatf("got %0d cycles want 4", c));
      drain();

      send(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0});
      send(16'h0005, 16'h0005, 1'b0, {16'h0000, 1'b0, 1'b0, 1'b1});
      send(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});
      send(16'h7FFF, 16'hFFFF, 1'b1, {16'h7FFF, 1'b1, 1'b0, 1'b0});
      drain();

      // Reset with three operations in flight: none of them may emerge.
      repeat (3) rand_op();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check(out_valid == 1'b0, "midrst_out_valid", $sformatf("got %b want 0", out_valid));
      check(diff == '0, "midrst_diff", $sformatf("got %h want 0000", diff));
      check(in_ready == 1'b1, "midrst_in_ready", $sformatf("got %b want 1", in_ready));
      c = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (out_valid) c++;
      end
      check(c == 0, "midrst_no_stale", $sformatf("got %0d valid cycles want 0", c));

      // Backpressure: 8 back-to-back ops, ready held low 5 cycles from the first result.
      fork
         begin
            repeat (8) rand_op();
         end
         begin
            int w;
            w = 0;
            do begin
               @(posedge clk);
               #1;
               w++;
            end while (!out_valid && w < 50);
            check(out_valid == 1'b1, "bp_first_valid", $sformatf("got %b want 1", out_valid));
            rdy_mode = 1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               #1;
               check(in_ready == 1'b0, "bp_in_ready", $sformatf("cycle %0d got %b want 0", i, in_ready));
               if (sb.size() != 0)
                  check(out_valid && diff == sb[0].diff && bout == sb[0].bout && ovf == sb[0].ovf,
                        "bp_hold", $sformatf("cycle %0d got v=%b diff=%h want v=1 diff=%h",
                                             i, out_valid, diff, sb[0].diff));
               else
                  check(1'b0, "bp_hold", "scoreboard empty during stall, want 8 pending");
            end
            rdy_mode = 0;
         end
      join
      drain();

      rdy_mode = 2;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         rand_op();
      end
      drain();
      rdy_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
